ddr_rx_ctrl: RTL

DDR_RX_CTRL -- requirements
Module: ddr_rx_ctrl

---
 rtl/ddr_rx_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ddr_rx_ctrl.sv
// DDR receive word aligner: flushes, hunts for SYNC_PAT by bit-slipping, locks, then delivers words with a valid/ready handshake.
// Optional drop counter output OVF_CNT is built when DDR_RX_CTRL_OVFCNT_EN is defined.
module ddr_rx_ctrl #(
  parameter int unsigned       WIDTH    = 8,
  parameter logic [WIDTH-1:0]  SYNC_PAT = 8'hA5,
  parameter int unsigned       LOCK_CNT = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic             EN,
  input  logic             Q0,
  input  logic             Q1,
  output logic             CE,
  output logic             CLR,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             LOCKED,
  output logic [3:0]       BIT_OFS,
  output logic             OVF
`ifdef DDR_RX_CTRL_OVFCNT_EN
  ,
  output logic [7:0]       OVF_CNT
`endif
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FLUSH = 3'd1;
  localparam logic [2:0] ST_HUNT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_LOCK  = 3'd4;

  localparam logic [3:0] PH_LAST  = 4'(WIDTH / 2 - 1);
  localparam logic [3:0] FL_LAST  = 4'(WIDTH - 1);
  localparam logic [3:0] OFS_LAST = 4'(WIDTH - 1);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);

  logic [2:0]         state;
  logic [2*WIDTH-1:0] sr;
  logic [3:0]         phase;
  logic [3:0]         flush_cnt;
  logic [3:0]         match_cnt;
  logic [3:0]         bit_ofs;
  logic [WIDTH-1:0]   dout_q;
  logic               dvalid_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   cand;
  logic               strobe;
  logic               hit;
  logic               ce_w;
`ifdef DDR_RX_CTRL_OVFCNT_EN
  logic [7:0]         ovf_cnt_q;
`endif

  always_comb begin
    ce_w   = (state != ST_IDLE);
    strobe = ((state == ST_HUNT) || (state == ST_CHECK) || (state == ST_LOCK)) &&
             (phase == PH_LAST);
    cand   = sr[bit_ofs +: WIDTH];
    hit    = (cand == SYNC_PAT);
  end

  // The pair keeps shifting whenever CE is high, including the edge that leaves for IDLE.
  always_ff @(posedge C) begin
    if (R) begin
      sr <= '0;
    end else if (ce_w) begin
      sr <= {sr[2*WIDTH-3:0], Q0, Q1};
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state     <= ST_IDLE;
      phase     <= '0;
      flush_cnt <= '0;
      match_cnt <= '0;
      bit_ofs   <= '0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef DDR_RX_CTRL_OVFCNT_EN
      ovf_cnt_q <= '0;
`endif
    end else if (!EN) begin
      state     <= ST_IDLE;
      phase     <= '0;
      flush_cnt <= '0;
      match_cnt <= '0;
      dvalid_q  <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef DDR_RX_CTRL_OVFCNT_EN
      ovf_cnt_q <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_FLUSH;
          flush_cnt <= '0;
          match_cnt <= '0;
          bit_ofs   <= '0;
          phase     <= '0;
        end
        ST_FLUSH: begin
          bit_ofs   <= '0;
          match_cnt <= '0;
          if (flush_cnt == FL_LAST) begin
            state <= ST_HUNT;
            phase <= '0;
          end else begin
            flush_cnt <= flush_cnt + 4'd1;
          end
        end
        ST_HUNT, ST_CHECK, ST_LOCK: begin
          phase <= strobe ? '0 : phase + 4'd1;
          if (strobe) begin
            if (state == ST_LOCK) begin
              if (dvalid_q && !DREADY) begin
                ovf_q <= 1'b1;
`ifdef DDR_RX_CTRL_OVFCNT_EN
                if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
`endif
              end else begin
                dout_q   <= cand;
                dvalid_q <= 1'b1;
              end
            end else if (hit) begin
              // match_cnt is always zero in HUNT, so one compare covers both states.
              state     <= (match_cnt + 4'd1 == LOCK_N) ? ST_LOCK : ST_CHECK;
              match_cnt <= match_cnt + 4'd1;
            end else begin
              match_cnt <= '0;
              if (bit_ofs == OFS_LAST) begin
                bit_ofs   <= '0;
                flush_cnt <= '0;
                state     <= ST_FLUSH;
              end else begin
                bit_ofs <= bit_ofs + 4'd1;
                state   <= ST_HUNT;
              end
            end
          end else if ((state == ST_LOCK) && dvalid_q && DREADY) begin
            dvalid_q <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign CE      = ce_w;
  assign CLR     = ~ce_w;
  assign DOUT    = dout_q;
  assign DVALID  = dvalid_q;
  assign LOCKED  = (state == ST_LOCK);
  assign BIT_OFS = bit_ofs;
  assign OVF     = ovf_q;
`ifdef DDR_RX_CTRL_OVFCNT_EN
  assign OVF_CNT = ovf_cnt_q;
`endif

endmodule
